// File: rtl/bakraid_cen_ctrl_pkg.sv
// Shared constants, channel enumeration and reset ratios for the Bakraid clock-enable controller.
package bakraid_cen_pkg;

  localparam int NCH = 4;
  localparam int W   = 12;

  typedef enum logic [1:0] {
    CH_GP9001   = 2'd0,
    CH_GP9001X2 = 2'd1,
    CH_Z80      = 2'd2,
    CH_YMZ      = 2'd3
  } cen_ch_e;

  function automatic logic [W-1:0] def_n(input int ch);
    case (ch)
      int'(CH_GP9001):   def_n = W'(9);
      int'(CH_GP9001X2): def_n = W'(9);
      int'(CH_Z80):      def_n = W'(1);
      int'(CH_YMZ):      def_n = W'(441);
      default:           def_n = W'(0);
    endcase
  endfunction

  function automatic logic [W-1:0] def_m(input int ch);
    case (ch)
      int'(CH_GP9001):   def_m = W'(128);
      int'(CH_GP9001X2): def_m = W'(64);
      int'(CH_Z80):      def_m = W'(18);
      int'(CH_YMZ):      def_m = W'(2500);
      default:           def_m = W'(1);
    endcase
  endfunction

endpackage

// File: rtl/bakraid_cen_ctrl_if.sv
// Ratio configuration port: write strobe with channel/n/m, answered by a registered ack/err pair.
interface bakraid_cen_ctrl_if;
  import bakraid_cen_pkg::*;

  logic         we;
  logic [1:0]   ch;
  logic [W-1:0] n;
  logic [W-1:0] m;
  logic         ack;
  logic         err;

  modport master (output we, ch, n, m, input ack, err);
  modport slave  (input we, ch, n, m, output ack, err);

endinterface

// File: rtl/bakraid_cen_ctrl_chan.sv
// One fractional clock-enable channel: n/m accumulator, shadow ratio with deferred apply, CEN/CENB strobes.
module bakraid_cen_chan
  import bakraid_cen_pkg::*;
#(
  parameter logic [W-1:0] P_DEF_N = W'(1),
  parameter logic [W-1:0] P_DEF_M = W'(1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_adv,
  input  logic         i_sync,
  input  logic         i_wr,
  input  logic [W-1:0] i_wr_n,
  input  logic [W-1:0] i_wr_m,
  output logic         o_cen,
  output logic         o_cenb,
  output logic         o_pending
);

  logic [W:0]   r_acc;
  logic [W-1:0] r_n, r_m, r_sh_n, r_sh_m;
  logic         r_pend, r_cen, r_cenb;

  logic [W:0] w_s, w_m, w_half;
  logic       w_run, w_wrap, w_apply;

  assign w_s    = r_acc + {1'b0, r_n};
  assign w_m    = {1'b0, r_m};
  assign w_half = {2'b00, r_m[W-1:1]};
  assign w_run  = i_adv && (r_n != '0);
  assign w_wrap = w_run && (w_s >= w_m);
  // A disabled channel has no wrap to wait for, so its shadow lands straight away.
  assign w_apply = r_pend && (w_wrap || (r_n == '0) || i_sync);

  // Accumulator, strobes, shadow ratio and pending flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_n    <= P_DEF_N;
      r_m    <= P_DEF_M;
      r_sh_n <= P_DEF_N;
      r_sh_m <= P_DEF_M;
      r_pend <= 1'b0;
      r_cen  <= 1'b0;
      r_cenb <= 1'b0;
    end else begin
      if (i_wr) begin
        r_sh_n <= i_wr_n;
        r_sh_m <= i_wr_m;
      end
      // A write colliding with an apply is held: the old shadow goes active, pending stays up.
      r_pend <= i_wr || (r_pend && !w_apply);
      if (i_sync) begin
        r_acc  <= '0;
        r_cen  <= 1'b0;
        r_cenb <= 1'b0;
      end else begin
        r_cen  <= w_wrap;
        r_cenb <= w_run && (r_acc < w_half) && (w_s >= w_half) && (w_s < w_m);
        if (w_run) begin
          r_acc <= w_wrap ? (w_s - w_m) : w_s;
        end
      end
      if (w_apply) begin
        r_n   <= r_sh_n;
        r_m   <= r_sh_m;
        r_acc <= '0;
      end
    end
  end

  assign o_cen     = r_cen;
  assign o_cenb    = r_cenb;
  assign o_pending = r_pend;

endmodule

// File: rtl/bakraid_cen_ctrl.sv
// Multi-channel fractional clock-enable controller on CLK96: config validation, ack/err, pause/step.
// Optional BAKRAID_CEN_PHASE_ALIGN_EN adds i_sync to clear and phase-align all channels.
module bakraid_cen_ctrl
  import bakraid_cen_pkg::*;
(
  input  logic              i_clk96,
  input  logic              i_reset96,
`ifdef BAKRAID_CEN_PHASE_ALIGN_EN
  input  logic              i_sync,
`endif
  input  logic              i_pause,
  input  logic              i_step,
  bakraid_cen_ctrl_if.slave io_cfg,
  output logic [NCH-1:0]    o_pending,
  output logic [NCH-1:0]    o_cen,
  output logic [NCH-1:0]    o_cenb
);

  logic r_ack, r_err;
  logic w_valid, w_adv, w_sync;

  assign w_valid = (io_cfg.m != '0) && (io_cfg.n <= io_cfg.m) && (32'(io_cfg.ch) < NCH);
  assign w_adv   = !i_pause || i_step;

`ifdef BAKRAID_CEN_PHASE_ALIGN_EN
  assign w_sync = i_sync;
`else
  assign w_sync = 1'b0;
`endif

  // Write acknowledge and rejection flag, one cycle after the strobe.
  always_ff @(posedge i_clk96) begin
    if (i_reset96) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= io_cfg.we;
      r_err <= io_cfg.we && !w_valid;
    end
  end

  assign io_cfg.ack = r_ack;
  assign io_cfg.err = r_err;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic w_wr;
    assign w_wr = io_cfg.we && w_valid && (32'(io_cfg.ch) == g);

    bakraid_cen_chan #(
      .P_DEF_N (def_n(g)),
      .P_DEF_M (def_m(g))
    ) u_chan (
      .i_clk     (i_clk96),
      .i_rst     (i_reset96),
      .i_adv     (w_adv),
      .i_sync    (w_sync),
      .i_wr      (w_wr),
      .i_wr_n    (io_cfg.n),
      .i_wr_m    (io_cfg.m),
      .o_cen     (o_cen[g]),
      .o_cenb    (o_cenb[g]),
      .o_pending (o_pending[g])
    );
  end

endmodule

// File: tb/tb_bakraid_cen_ctrl.sv
// Directed bench for bakraid_cen_ctrl: default cadences, reconfiguration, rejects, pause/step, reset.
module tb_bakraid_cen_ctrl;
  import bakraid_cen_pkg::*;

  logic           clk = 1'b0;
  logic           rst, pause, step, sync;
  logic [NCH-1:0] cen, cenb, pend;
  int             n_tests = 0;
  int             n_fail  = 0;

  always #5 clk = ~clk;

  bakraid_cen_ctrl_if u_if ();

  bakraid_cen_ctrl u_dut (
    .i_clk96   (clk),
    .i_reset96 (rst),
`ifdef BAKRAID_CEN_PHASE_ALIGN_EN
    .i_sync    (sync),
`endif
    .i_pause   (pause),
    .i_step    (step),
    .io_cfg    (u_if),
    .o_pending (pend),
    .o_cen     (cen),
    .o_cenb    (cenb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int n, input int m);
    u_if.we = 1'b1;
    u_if.ch = 2'(ch);
    u_if.n  = W'(n);
    u_if.m  = W'(m);
    tick();
    u_if.we = 1'b0;
  endtask

  task automatic run_to_cen(input int ch, input int lim, output int gap, output int nb);
    gap = 0;
    nb  = 0;
    do begin
      tick();
      gap++;
      nb += int'(cenb[ch]);
    end while (!cen[ch] && gap < lim);
  endtask

  task automatic count_cen(input int cycles, output int c0, output int c1, output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      c0 += int'(cen[0]); c1 += int'(cen[1]); c2 += int'(cen[2]); c3 += int'(cen[3]);
    end
  endtask

  initial begin
    int c0, c1, c2, c3, gap, nb, bad, hits, drops;
    logic [3:0]     pat;
    logic [NCH-1:0] pend_before;

    rst = 1'b1; pause = 1'b0; step = 1'b0; sync = 1'b0;
    u_if.we = 1'b0; u_if.ch = 2'd0; u_if.n = '0; u_if.m = '0;
    tick(); tick();
    chk("rst_cen", 32'(cen), 32'd0);
    chk("rst_cenb", 32'(cenb), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_ack", 32'(u_if.ack), 32'd0);
    chk("rst_err", 32'(u_if.err), 32'd0);
    rst = 1'b0;

    // Default ratios from reset: floor(1280*n/m) strobes each.
    count_cen(1280, c0, c1, c2, c3);
    chk("t1_cnt0", 32'(c0), 32'd90);
    chk("t1_cnt1", 32'(c1), 32'd180);
    chk("t1_cnt2", 32'(c2), 32'd71);
    chk("t1_cnt3", 32'(c3), 32'd225);

    run_to_cen(2, 40, gap, nb);
    chk("t2_sync", 32'(cen[2]), 32'd1);
    for (int p = 0; p < 2; p++) begin
      run_to_cen(2, 40, gap, nb);
      chk("t2_gap", 32'(gap), 32'd18);
      chk("t2_cenb", 32'(nb), 32'd1);
    end

    // Write right after a ch3 wrap so it cannot collide with one.
    run_to_cen(3, 20, gap, nb);
    chk("t3_sync", 32'(cen[3]), 32'd1);
    cfg_write(3, 1, 2);
    chk("t3_ack", 32'(u_if.ack), 32'd1);
    chk("t3_err", 32'(u_if.err), 32'd0);
    chk("t3_pend_set", 32'(pend[3]), 32'd1);
    run_to_cen(3, 20, gap, nb);
    chk("t3_wrap", 32'(cen[3]), 32'd1);
    chk("t3_pend_clr", 32'(pend[3]), 32'd0);
    pat = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat = {pat[2:0], cen[3]};
    end
    chk("t3_cadence", 32'(pat), 32'b0101);

    pend_before = pend;
    cfg_write(0, 5, 3);
    chk("t4_ack_nm", 32'(u_if.ack), 32'd1);
    chk("t4_err_nm", 32'(u_if.err), 32'd1);
    chk("t4_pend_nm", 32'(pend), 32'(pend_before));
    cfg_write(0, 3, 0);
    chk("t4_ack_m0", 32'(u_if.ack), 32'd1);
    chk("t4_err_m0", 32'(u_if.err), 32'd1);
    chk("t4_pend_m0", 32'(pend), 32'(pend_before));
    count_cen(128, c0, c1, c2, c3);
    chk("t4_cnt0", 32'(c0), 32'd9);
    chk("t4_cnt3", 32'(c3), 32'd64);

    // Pause with 18 steps spread over 100 clocks.
    c2 = 0; c3 = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      pause = 1'b1;
      step  = ((i % 5) == 2) && (i < 90);
      tick();
      c2 += int'(cen[2]);
      c3 += int'(cen[3]);
      if (!step && ((cen | cenb) != '0)) bad++;
    end
    pause = 1'b0;
    step  = 1'b0;
    chk("t5_cen2", 32'(c2), 32'd1);
    chk("t5_cen3", 32'(c3), 32'd9);
    chk("t5_quiet", 32'(bad), 32'd0);

    // Land a write exactly on the ch2 wrap 18 clocks after a seen strobe.
    run_to_cen(2, 40, gap, nb);
    chk("t6_sync", 32'(cen[2]), 32'd1);
    for (int i = 0; i < 17; i++) tick();
    cfg_write(2, 1, 3);
    chk("t6_wrap", 32'(cen[2]), 32'd1);
    chk("t6_pend_held", 32'(pend[2]), 32'd1);
    chk("t6_ack", 32'(u_if.ack), 32'd1);
    hits = 0; drops = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      hits  += int'(cen[2]);
      drops += int'(!pend[2]);
    end
    chk("t6_old_ratio", 32'(hits), 32'd0);
    chk("t6_pend_kept", 32'(drops), 32'd0);
    tick();
    chk("t6_wrap2", 32'(cen[2]), 32'd1);
    chk("t6_pend_clr", 32'(pend[2]), 32'd0);
    pat = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pat = {pat[2:0], cen[2]};
    end
    chk("t6_new_ratio", 32'(pat), 32'b001);

    cfg_write(1, 1, 4);
    chk("t7_pend_set", 32'(pend[1]), 32'd1);
    rst = 1'b1;
    u_if.we = 1'b1; u_if.ch = 2'd0; u_if.n = W'(1); u_if.m = W'(2);
    tick();
    u_if.we = 1'b0;
    chk("t7_ack", 32'(u_if.ack), 32'd0);
    chk("t7_pend", 32'(pend), 32'd0);
    chk("t7_cen", 32'(cen), 32'd0);
    chk("t7_cenb", 32'(cenb), 32'd0);
    rst = 1'b0;
    count_cen(128, c0, c1, c2, c3);
    chk("t7_cnt0", 32'(c0), 32'd9);
    chk("t7_cnt1", 32'(c1), 32'd18);
    chk("t7_cnt2", 32'(c2), 32'd7);
    chk("t7_cnt3", 32'(c3), 32'd22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
